// File: rtl/chunked_adder_rf_if.sv
// Register-bus bundle for chunked_adder_rf: address/data/strobes in, read data and status pulses out.
interface chunked_adder_rf_if #(
  parameter int unsigned N = 16
);
  logic [2:0]   i_addr;
  logic [N-1:0] i_data;
  logic         i_we;
  logic         i_re;
  logic         i_start;
  logic [N-1:0] o_data;
  logic         o_ack;
  logic         o_ready;
  logic         o_busy;

  modport master (
    output i_addr, i_data, i_we, i_re, i_start,
    input  o_data, o_ack, o_ready, o_busy
  );

  modport slave (
    input  i_addr, i_data, i_we, i_re, i_start,
    output o_data, o_ack, o_ready, o_busy
  );
endinterface

// File: rtl/chunked_adder_rf.sv
// Register-mapped N-bit add/subtract unit that runs one W-bit chunk per clock, LSB first,
// and commits RESULT/STATUS atomically. N must be a multiple of W with at least two chunks.
module chunked_adder_rf #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 4
) (
  input logic               i_clk,
  input logic               i_rst,
  chunked_adder_rf_if.slave bus
);

  localparam int unsigned K    = N / W;
  localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(K - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StCalc = 1'b1;

  logic [0:0]      state_q;
  logic [CntW-1:0] cnt_q;

  // Programmer-visible registers
  logic         sub_q;
  logic         cin_q;
  logic [N-1:0] data1_q;
  logic [N-1:0] data2_q;
  logic [N-1:0] result_q;
  logic         cout_q;
  logic         ovf_q;

  // Snapshot of the operation in flight, isolated from bus writes
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic         sub_op_q;
  logic         carry_q;
  logic [N-1:0] acc_q;

  logic [N-1:0] beff;
  logic [N-1:0] acc_d;
  logic [N-1:0] rd_val;
  logic [W:0]   chunk_sum;
  int unsigned  base;

  always_comb begin
    base      = 32'(cnt_q) * W;
    beff      = sub_op_q ? ~b_q : b_q;
    chunk_sum = {1'b0, a_q[base +: W]} + {1'b0, beff[base +: W]} + {{W{1'b0}}, carry_q};
    acc_d              = acc_q;
    acc_d[base +: W]   = chunk_sum[W-1:0];
  end

  always_comb begin
    rd_val = '0;
    case (bus.i_addr)
      3'd0:    rd_val = {{(N-1){1'b0}}, sub_q};
      3'd1:    rd_val = data1_q;
      3'd2:    rd_val = data2_q;
      3'd3:    rd_val = {{(N-1){1'b0}}, cin_q};
      3'd4:    rd_val = result_q;
      3'd5:    rd_val = {{(N-3){1'b0}}, (state_q == StCalc), ovf_q, cout_q};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sub_q       <= 1'b0;
      cin_q       <= 1'b0;
      data1_q     <= '0;
      data2_q     <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sub_op_q    <= 1'b0;
      carry_q     <= 1'b0;
      acc_q       <= '0;
      bus.o_data  <= '0;
      bus.o_ack   <= 1'b0;
      bus.o_ready <= 1'b0;
      bus.o_busy  <= 1'b0;
    end else begin
      bus.o_ack   <= 1'b0;
      bus.o_ready <= 1'b0;

      // A write strobe masks any simultaneous read
      if (bus.i_we) begin
        if (!bus.i_addr[2]) begin
          bus.o_ack <= 1'b1;
          unique case (bus.i_addr[1:0])
            2'd0: sub_q   <= bus.i_data[0];
            2'd1: data1_q <= bus.i_data;
            2'd2: data2_q <= bus.i_data;
            2'd3: cin_q   <= bus.i_data[0];
          endcase
        end
      end else if (bus.i_re) begin
        bus.o_data <= rd_val;
        bus.o_ack  <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (bus.i_start) begin
            a_q        <= data1_q;
            b_q        <= data2_q;
            sub_op_q   <= sub_q;
            // Subtract is A + ~B + ~CIN, so the borrow-in becomes an inverted carry-in
            carry_q    <= sub_q ? ~cin_q : cin_q;
            cnt_q      <= '0;
            acc_q      <= '0;
            bus.o_busy <= 1'b1;
            state_q    <= StCalc;
          end
        end
        StCalc: begin
          acc_q   <= acc_d;
          carry_q <= chunk_sum[W];
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            result_q    <= acc_d;
            cout_q      <= chunk_sum[W];
            ovf_q       <= (a_q[N-1] == beff[N-1]) && (acc_d[N-1] != a_q[N-1]);
            bus.o_ready <= 1'b1;
            bus.o_busy  <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_adder_rf.sv
// Self-checking bench for chunked_adder_rf: directed vector table, random ops against an
// arithmetic model, and hand-written sequences for busy isolation, abort and back-to-back start.
module tb_chunked_adder_rf;

  localparam int unsigned N = 16;
  localparam int unsigned W = 4;
  localparam int unsigned K = N / W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  chunked_adder_rf_if #(.N(N)) bus ();

  chunked_adder_rf #(.N(N), .W(W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int ready_pulses = 0;

  always @(posedge clk) if (bus.o_ready === 1'b1) ready_pulses <= ready_pulses + 1;

  typedef struct {
    logic        sub;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] r;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] addr, input logic [15:0] data);
    bus.i_addr = addr;
    bus.i_data = data;
    bus.i_we   = 1'b1;
    tick();
    bus.i_we   = 1'b0;
    check("wr_ack", 32'(bus.o_ack), (addr < 3'd4) ? 32'd1 : 32'd0);
  endtask

  task automatic rd(input logic [2:0] addr, output logic [15:0] data);
    bus.i_addr = addr;
    bus.i_re   = 1'b1;
    tick();
    bus.i_re   = 1'b0;
    data       = bus.o_data;
    check("rd_ack", 32'(bus.o_ack), 32'd1);
  endtask

  task automatic prog(input logic sub, input logic [15:0] a, input logic [15:0] b,
                      input logic cin);
    wr(3'd0, {15'd0, sub});
    wr(3'd1, a);
    wr(3'd2, b);
    wr(3'd3, {15'd0, cin});
  endtask

  // Start, check the K-cycle busy window and ready timing, then read RESULT and STATUS.
  task automatic run_op(output logic [15:0] r, output logic [15:0] st);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check("busy_after_start", 32'(bus.o_busy), 32'd1);
    for (int i = 1; i <= int'(K); i++) begin
      tick();
      check("latency", {30'd0, bus.o_busy, bus.o_ready}, (i < int'(K)) ? 32'd2 : 32'd1);
    end
    rd(3'd4, r);
    rd(3'd5, st);
  endtask

  // Reference: plain integer arithmetic on the architectural operands.
  function automatic void model(input logic sub, input logic [15:0] a, input logic [15:0] b,
                                input logic cin, output logic [15:0] r, output logic cout,
                                output logic ovf);
    longint ua, ub, sa, sb, c, u, s;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = longint'(cin);
    if (sub) begin
      u    = ua - ub - c;
      s    = sa - sb - c;
      cout = (u >= 0);
    end else begin
      u    = ua + ub + c;
      s    = sa + sb + c;
      cout = (u >= 65536);
    end
    r   = u[15:0];
    ovf = (s > 32767) || (s < -32768);
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] r, st, d, prev_r, er;
    logic        ec, eo;
    int          base;
    logic        got;

    vecs[0] = '{sub: 1'b0, a: 16'h1234, b: 16'h0FFF, cin: 1'b1, r: 16'h2234, cout: 1'b0, ovf: 1'b0};
    vecs[1] = '{sub: 1'b0, a: 16'hFFFF, b: 16'h0001, cin: 1'b0, r: 16'h0000, cout: 1'b1, ovf: 1'b0};
    vecs[2] = '{sub: 1'b0, a: 16'h7FFF, b: 16'h0001, cin: 1'b0, r: 16'h8000, cout: 1'b0, ovf: 1'b1};
    vecs[3] = '{sub: 1'b1, a: 16'h0005, b: 16'h0007, cin: 1'b0, r: 16'hFFFE, cout: 1'b0, ovf: 1'b0};
    vecs[4] = '{sub: 1'b1, a: 16'h8000, b: 16'h0001, cin: 1'b0, r: 16'h7FFF, cout: 1'b1, ovf: 1'b1};
    vecs[5] = '{sub: 1'b1, a: 16'h0000, b: 16'h0000, cin: 1'b1, r: 16'hFFFF, cout: 1'b0, ovf: 1'b0};

    bus.i_addr  = '0;
    bus.i_data  = '0;
    bus.i_we    = 1'b0;
    bus.i_re    = 1'b0;
    bus.i_start = 1'b0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("reset_ready", 32'(bus.o_ready), 32'd0);
    check("reset_busy", 32'(bus.o_busy), 32'd0);
    for (int a = 0; a < 6; a++) begin
      rd(3'(a), d);
      check("reset_reg", 32'(d), 32'd0);
    end

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      prog(vecs[i].sub, vecs[i].a, vecs[i].b, vecs[i].cin);
      run_op(r, st);
      check("vec_result", 32'(r), 32'(vecs[i].r));
      check("vec_status", 32'(st), {29'd0, 1'b0, vecs[i].ovf, vecs[i].cout});
      prev_r = r;
    end

    // Random operations against the model
    for (int i = 0; i < 40; i++) begin
      logic        s, c;
      logic [15:0] a, b;
      s = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      a = 16'($urandom);
      b = 16'($urandom);
      model(s, a, b, c, er, ec, eo);
      prog(s, a, b, c);
      run_op(r, st);
      check("rand_result", 32'(r), 32'(er));
      check("rand_status", 32'(st), {29'd0, 1'b0, eo, ec});
      prev_r = r;
    end

    // Busy isolation: writes and a second start during CALC must not disturb the operation
    prog(1'b0, 16'h0010, 16'h0020, 1'b0);
    base = ready_pulses;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    check("iso_busy", 32'(bus.o_busy), 32'd1);
    bus.i_we    = 1'b1;
    bus.i_addr  = 3'd1;
    bus.i_data  = 16'hFFFF;
    bus.i_start = 1'b1;
    tick();
    bus.i_we    = 1'b0;
    bus.i_start = 1'b0;
    check("iso_wr_ack", 32'(bus.o_ack), 32'd1);
    bus.i_re   = 1'b1;
    bus.i_addr = 3'd4;
    tick();
    check("iso_prev_result", 32'(bus.o_data), 32'(prev_r));
    bus.i_addr = 3'd5;
    tick();
    bus.i_re = 1'b0;
    check("iso_status_busy", 32'(bus.o_data[2]), 32'd1);
    tick();
    check("iso_done", {30'd0, bus.o_busy, bus.o_ready}, 32'd1);
    for (int i = 0; i < 6; i++) tick();
    check("iso_one_ready", 32'(ready_pulses - base), 32'd1);
    rd(3'd4, d);
    check("iso_result", 32'(d), 32'h0030);
    rd(3'd1, d);
    check("iso_data1", 32'(d), 32'hFFFF);

    // Abort by reset mid-computation
    prog(1'b0, 16'h1111, 16'h2222, 1'b0);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = ready_pulses;
    check("abort_busy_ready", {30'd0, bus.o_busy, bus.o_ready}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("abort_no_ready", 32'(ready_pulses - base), 32'd0);
    rd(3'd4, d);
    check("abort_result", 32'(d), 32'd0);
    rd(3'd5, d);
    check("abort_status", 32'(d), 32'd0);

    // Illegal accesses
    wr(3'd4, 16'hABCD);
    rd(3'd4, d);
    check("ro_result_unchanged", 32'(d), 32'd0);
    rd(3'd7, d);
    check("unmapped7", 32'(d), 32'd0);
    rd(3'd6, d);
    check("unmapped6", 32'(d), 32'd0);

    // Back-to-back: start held high re-triggers in the o_ready cycle
    prog(1'b0, 16'h0001, 16'h0002, 1'b0);
    bus.i_start = 1'b1;
    tick();
    bus.i_we   = 1'b1;
    bus.i_addr = 3'd2;
    bus.i_data = 16'h0005;
    tick();
    bus.i_we = 1'b0;
    check("b2b_wr_ack", 32'(bus.o_ack), 32'd1);
    for (int i = 0; i < int'(K) - 1; i++) tick();
    check("b2b_first_done", {30'd0, bus.o_busy, bus.o_ready}, 32'd1);
    bus.i_re   = 1'b1;
    bus.i_addr = 3'd4;
    tick();
    bus.i_re    = 1'b0;
    bus.i_start = 1'b0;
    check("b2b_retrigger", {30'd0, bus.o_busy, bus.o_ready}, 32'd2);
    check("b2b_first_result", 32'(bus.o_data), 32'h0003);
    got = 1'b0;
    for (int i = 0; i < int'(K) + 2 && !got; i++) begin
      tick();
      if (bus.o_ready === 1'b1) got = 1'b1;
    end
    check("b2b_second_ready", 32'(got), 32'd1);
    rd(3'd4, d);
    check("b2b_second_result", 32'(d), 32'h0006);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chunked_adder_rf.md
Name: chunked_adder_rf

Overview:
- Next-generation register-file-mapped adder/subtractor.
- Operand width N is split into K = N/W chunks, processed LSB-first, one chunk per clock, through a single W-bit adder slice.
- Adds a subtract mode, a signed-overflow flag, a busy indicator, explicit read strobes and atomic result commit.
- Sits on the same simple register bus as the existing adder blocks and replaces the fixed two-half adder.

Parameters:
- N, 16, total operand/result width; must be a multiple of W.
- W, 4, chunk width processed per cycle; K = N/W chunks, K >= 2.

Ports:
- i_clk    input   1   clock, all logic on rising edge.
- i_rst    input   1   synchronous reset, active-high.
- i_addr   input   3   register address.
- i_data   input   N   write data.
- i_we     input   1   write strobe.
- i_re     input   1   read strobe; ignored when i_we is high.
- i_start  input   1   start computation; sampled only in IDLE.
- o_data   output  N   registered read data.
- o_ack    output  1   one-cycle pulse acknowledging an accepted write or read.
- o_ready  output  1   one-cycle pulse: RESULT/STATUS updated.
- o_busy   output  1   high while computation is in flight.

Behaviour:
- Register map:
  - 0 CONFIG R/W, bit0 SUB; other bits read 0.
  - 1 DATA1 R/W.
  - 2 DATA2 R/W.
  - 3 CIN R/W, bit0 only.
  - 4 RESULT RO.
  - 5 STATUS RO: bit0 COUT, bit1 OVF, bit2 BUSY (live).
  - 6-7 unmapped.
- Reset: at an i_rst edge, all registers, o_data, o_ack, o_ready and o_busy go to 0; state IDLE; chunk counter 0. Reset mid-computation aborts it; RESULT/STATUS read 0, and no o_ready pulse occurs.
- Write (i_we=1, addr 0-3): register updated at the edge; o_ack=1 the next cycle.
- Write to addr 4-7: ignored, no o_ack.
- Read (i_re=1, i_we=0): o_data <= register at the edge; o_ack=1 the next cycle. Unmapped addresses return 0 with o_ack. o_data holds its value otherwise.
- FSM states: IDLE, CALC.
  - IDLE -> CALC on i_start at an edge. At that edge:
    - snapshot A=DATA1, B=DATA2, S=SUB, C=CIN using the pre-edge register values; a same-edge write is not captured;
    - counter=0; o_busy=1.
  - CALC: each edge processes chunk j=counter:
    - sum = A[j] + Beff[j] + carry, where Beff = S ? ~B : B;
    - initial carry = S ? ~C : C;
    - chunk result goes to an internal accumulator; carry is registered; counter increments.
  - CALC -> IDLE on the edge processing chunk K-1. At that edge:
    - RESULT <= full accumulator; COUT <= final carry;
    - OVF <= (A[N-1]==Beff[N-1]) && (R[N-1]!=A[N-1]);
    - o_ready=1 for exactly one cycle; o_busy=0.
- Latency: with start sampled at edge e0, o_busy is high for K cycles and o_ready is high in the cycle after edge eK.
- Sub semantics: RESULT = DATA1 - DATA2 - CIN mod 2^N. COUT=1 means no borrow.
- RESULT/STATUS never show partial values; both are committed together.
- i_start while in CALC: ignored, no queuing.
- Writes during CALC: accepted and acked, but do not affect the in-flight operation.
- Reads during CALC: return the previous RESULT; STATUS.BUSY=1.
- Back-to-back: i_start held high re-triggers on the edge after return to IDLE, i.e. the cycle o_ready is high.

Test Plan:
- N=16, W=4 reset: after i_rst, read addr 0-5 -> all 0 with o_ack; o_ready=0, o_busy=0.
- Basic add: DATA1=0x1234, DATA2=0x0FFF, CIN=1, SUB=0, start at e0 -> o_busy for 4 cycles; o_ready in the cycle after e4; RESULT=0x2234; STATUS COUT=0, OVF=0.
- Carry and overflow:
  - 0xFFFF+0x0001, CIN=0 -> RESULT=0x0000, COUT=1, OVF=0.
  - 0x7FFF+0x0001 -> RESULT=0x8000, COUT=0, OVF=1.
- Subtract: SUB=1, 0x0005-0x0007, CIN=0 -> RESULT=0xFFFE, COUT=0 (borrow), OVF=0.
  - 0x8000-0x0001 -> RESULT=0x7FFF, OVF=1, COUT=1.
- Busy isolation: start 0x0010+0x0020; during CALC write DATA1=0xFFFF and pulse i_start -> writes acked; RESULT=0x0030; only one o_ready; a later read of DATA1 returns 0xFFFF.
- Abort/illegal access:
  - assert i_rst on cycle 2 of CALC -> no o_ready; RESULT=0.
  - write to addr 4 -> no o_ack, value unchanged.
  - read addr 7 -> 0 with o_ack.
